// File: rtl/alu_trace_checker.sv
// alu_trace_checker
// Watches the execute stage of the Mips pipeline. Each valid sample is
// compared against the next entry of an expected-sample table. The block
// reports the mismatch count, the index of the first mismatch, a timeout
// flag and an overall pass flag.
//
// Ports
//   clock, reset       : single rising-edge clock, synchronous active-high reset
//   start              : pulse that begins a run; accepted only in IDLE or DONE
//   expected_count     : number of entries to check, sampled at start
//   exp_we/addr/wdata  : table write port {A, B, out, op}; ignored while busy
//   sample_valid, in_* : observed execute-stage sample
//   busy, done, pass   : run status
//   timeout            : the run was aborted because no samples arrived
//   err_count          : saturating mismatch count
//   first_err_valid/index : table index of the first mismatch
//   sample_index       : number of samples compared so far
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | comparing samples against the table
// DONE  | results held until the next start or reset
module alu_trace_checker #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          OP_WIDTH     = 3,
    parameter int          DEPTH        = 64,
    parameter int          ADDR_WIDTH   = 6,
    parameter logic [3:0]  COMPARE_MASK = 4'b1111,
    parameter int          TIMEOUT      = 256,
    parameter int          ERR_WIDTH    = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ADDR_WIDTH:0]                  expected_count,
    input  logic                                 exp_we,
    input  logic [ADDR_WIDTH-1:0]                exp_addr,
    input  logic [3*DATA_WIDTH+OP_WIDTH-1:0]     exp_wdata,
    input  logic                                 sample_valid,
    input  logic [DATA_WIDTH-1:0]                in_a,
    input  logic [DATA_WIDTH-1:0]                in_b,
    input  logic [DATA_WIDTH-1:0]                in_out,
    input  logic [OP_WIDTH-1:0]                  in_op,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic                                 timeout,
    output logic [ERR_WIDTH-1:0]                 err_count,
    output logic                                 first_err_valid,
    output logic [ADDR_WIDTH-1:0]                first_err_index,
    output logic [ADDR_WIDTH:0]                  sample_index
);

    localparam int EW = 3*DATA_WIDTH + OP_WIDTH;
    localparam int CW = ADDR_WIDTH + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          index_q, index_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic                   fev_q, fev_d;
    logic [ADDR_WIDTH-1:0]  fei_q, fei_d;
    logic                   timeout_q, timeout_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic                   pass_q, pass_d;

    logic [EW-1:0]          table_q [DEPTH];
    logic [EW-1:0]          entry;
    logic [3:0]             field_diff;
    logic                   mismatch;
    logic [CW-1:0]          count_clamped;

    // The table has no reset so a loaded table survives reset and is re-used.
    always_ff @(posedge clock) begin
        if (exp_we && state_q != RUN) begin
            table_q[exp_addr] <= exp_wdata;
        end
    end

    assign entry = table_q[index_q[ADDR_WIDTH-1:0]];

    assign field_diff = {
        in_a   != entry[EW-1 -: DATA_WIDTH],
        in_b   != entry[2*DATA_WIDTH+OP_WIDTH-1 -: DATA_WIDTH],
        in_out != entry[DATA_WIDTH+OP_WIDTH-1 -: DATA_WIDTH],
        in_op  != entry[OP_WIDTH-1:0]
    };
    assign mismatch = |(field_diff & COMPARE_MASK);

    assign count_clamped = (expected_count > DEPTH_C) ? DEPTH_C : expected_count;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        err_d     = err_q;
        fev_d     = fev_q;
        fei_d     = fei_q;
        timeout_d = timeout_q;
        idle_d    = idle_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    count_d   = count_clamped;
                    index_d   = '0;
                    err_d     = '0;
                    fev_d     = 1'b0;
                    fei_d     = '0;
                    timeout_d = 1'b0;
                    idle_d    = '0;
                    state_d   = (count_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    idle_d  = '0;
                    index_d = index_q + CW'(1);
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_WIDTH'(1);
                        end
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fei_d = index_q[ADDR_WIDTH-1:0];
                        end
                    end
                    if (index_q == count_q - CW'(1)) begin
                        state_d = DONE;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so pass lines up with done on the same cycle.
        pass_d = (state_d == DONE) && (err_d == '0) && !timeout_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            index_q   <= '0;
            err_q     <= '0;
            fev_q     <= 1'b0;
            fei_q     <= '0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            err_q     <= err_d;
            fev_q     <= fev_d;
            fei_q     <= fei_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
            pass_q    <= pass_d;
        end
    end

    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_index = fei_q;
    assign sample_index    = index_q;

endmodule

// File: tb/tb_alu_trace_checker.sv
module tb_alu_trace_checker;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [6:0]   expected_count;
    logic         exp_we;
    logic [5:0]   exp_addr;
    logic [98:0]  exp_wdata;
    logic         sample_valid;
    logic [31:0]  in_a, in_b, in_out;
    logic [2:0]   in_op;

    logic         f_busy, f_done, f_pass, f_to, f_fev;
    logic [7:0]   f_err;
    logic [5:0]   f_fei;
    logic [6:0]   f_si;

    logic         m_busy, m_done, m_pass, m_to, m_fev;
    logic [1:0]   m_err;
    logic [5:0]   m_fei;
    logic [6:0]   m_si;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_trace_checker #(
        .COMPARE_MASK(4'b1111), .TIMEOUT(16), .ERR_WIDTH(8)
    ) u_full (
        .clock(clock), .reset(reset), .start(start), .expected_count(expected_count),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata),
        .sample_valid(sample_valid), .in_a(in_a), .in_b(in_b), .in_out(in_out), .in_op(in_op),
        .busy(f_busy), .done(f_done), .pass(f_pass), .timeout(f_to), .err_count(f_err),
        .first_err_valid(f_fev), .first_err_index(f_fei), .sample_index(f_si)
    );

    // Same stimulus, but only out/op compared and a 2-bit error counter.
    alu_trace_checker #(
        .COMPARE_MASK(4'b0011), .TIMEOUT(16), .ERR_WIDTH(2)
    ) u_mask (
        .clock(clock), .reset(reset), .start(start), .expected_count(expected_count),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata),
        .sample_valid(sample_valid), .in_a(in_a), .in_b(in_b), .in_out(in_out), .in_op(in_op),
        .busy(m_busy), .done(m_done), .pass(m_pass), .timeout(m_to), .err_count(m_err),
        .first_err_valid(m_fev), .first_err_index(m_fei), .sample_index(m_si)
    );

    typedef struct {
        logic        st;
        logic [6:0]  cnt;
        logic        v;
        logic [31:0] a, b, o;
        logic [2:0]  op;
        logic        e_busy, e_done, e_pass;
        logic [7:0]  e_err;
        logic        e_fev;
        logic [5:0]  e_fei;
        logic [6:0]  e_si;
        logic        e_mpass;
        logic [1:0]  e_merr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic st, logic [6:0] cnt, logic v,
                                logic [31:0] a, logic [31:0] b, logic [31:0] o, logic [2:0] op,
                                logic eb, logic ed, logic ep, logic [7:0] ee,
                                logic efv, logic [5:0] efi, logic [6:0] esi,
                                logic emp, logic [1:0] eme);
        vec_t r;
        r.st = st; r.cnt = cnt; r.v = v; r.a = a; r.b = b; r.o = o; r.op = op;
        r.e_busy = eb; r.e_done = ed; r.e_pass = ep; r.e_err = ee;
        r.e_fev = efv; r.e_fei = efi; r.e_si = esi; r.e_mpass = emp; r.e_merr = eme;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic st, logic [6:0] cnt, logic v,
                         logic [31:0] a, logic [31:0] b, logic [31:0] o, logic [2:0] op);
        start = st; expected_count = cnt; sample_valid = v;
        in_a = a; in_b = b; in_out = o; in_op = op;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 7'd0, 1'b0, 32'd0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic write_entry(logic [5:0] addr, logic [31:0] a, logic [31:0] b,
                               logic [31:0] o, logic [2:0] op);
        exp_we = 1'b1; exp_addr = addr; exp_wdata = {a, b, o, op};
        tick();
        exp_we = 1'b0;
    endtask

    task automatic send_good_pair();
        drive(1'b0, 7'd0, 1'b1, 32'd1, 32'd2, 32'd3, 3'd2); tick();
        drive(1'b0, 7'd0, 1'b1, 32'd3, 32'd4, 32'd7, 3'd2); tick();
    endtask

    initial begin
        reset = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        idle_inputs();
        tick(); tick();
        reset = 1'b0;

        check("rst_busy", f_busy, 0);
        check("rst_done", f_done, 0);
        check("rst_pass", f_pass, 0);
        check("rst_err",  f_err, 0);
        check("rst_si",   f_si, 0);

        write_entry(6'd0, 32'd1,  32'd2,  32'd3,  3'd2);
        write_entry(6'd1, 32'd3,  32'd4,  32'd7,  3'd2);
        write_entry(6'd2, 32'd10, 32'd20, 32'd30, 3'd2);
        write_entry(6'd3, 32'd0,  32'd0,  32'd0,  3'd2);
        write_entry(6'd4, 32'd5,  32'd6,  32'd11, 3'd2);
        write_entry(6'd5, 32'd7,  32'd8,  32'd15, 3'd2);

        // all matching
        vt.push_back(mk(1, 4, 0, 0, 0, 0, 0,      1,0,0, 0, 0,0,0, 0,0));
        vt.push_back(mk(0, 0, 1, 1, 2, 3, 2,      1,0,0, 0, 0,0,1, 0,0));
        vt.push_back(mk(0, 0, 1, 3, 4, 7, 2,      1,0,0, 0, 0,0,2, 0,0));
        vt.push_back(mk(0, 0, 1, 10, 20, 30, 2,   1,0,0, 0, 0,0,3, 0,0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 2,      0,1,1, 0, 0,0,4, 1,0));
        // wrong result at index 2 and 3
        vt.push_back(mk(1, 4, 0, 0, 0, 0, 0,      1,0,0, 0, 0,0,0, 0,0));
        vt.push_back(mk(0, 0, 1, 1, 2, 3, 2,      1,0,0, 0, 0,0,1, 0,0));
        vt.push_back(mk(0, 0, 1, 3, 4, 7, 2,      1,0,0, 0, 0,0,2, 0,0));
        vt.push_back(mk(0, 0, 1, 10, 20, 31, 2,   1,0,0, 1, 1,2,3, 0,1));
        vt.push_back(mk(0, 0, 1, 0, 0, 5, 2,      0,1,0, 2, 1,2,4, 0,2));
        // operands wrong, result/op right; one idle cycle mid-run
        vt.push_back(mk(1, 4, 0, 0, 0, 0, 0,      1,0,0, 0, 0,0,0, 0,0));
        vt.push_back(mk(0, 0, 1, 101, 102, 3, 2,  1,0,0, 1, 1,0,1, 0,0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0,      1,0,0, 1, 1,0,1, 0,0));
        vt.push_back(mk(0, 0, 1, 103, 104, 7, 2,  1,0,0, 2, 1,0,2, 0,0));
        vt.push_back(mk(0, 0, 1, 110, 120, 30, 2, 1,0,0, 3, 1,0,3, 0,0));
        vt.push_back(mk(0, 0, 1, 100, 100, 0, 2,  0,1,0, 4, 1,0,4, 1,0));
        // six mismatches: 2-bit counter saturates at 3
        vt.push_back(mk(1, 6, 0, 0, 0, 0, 0,      1,0,0, 0, 0,0,0, 0,0));
        vt.push_back(mk(0, 0, 1, 1, 2, 4, 3,      1,0,0, 1, 1,0,1, 0,1));
        vt.push_back(mk(0, 0, 1, 3, 4, 8, 3,      1,0,0, 2, 1,0,2, 0,2));
        vt.push_back(mk(0, 0, 1, 10, 20, 31, 3,   1,0,0, 3, 1,0,3, 0,3));
        vt.push_back(mk(0, 0, 1, 0, 0, 1, 3,      1,0,0, 4, 1,0,4, 0,3));
        vt.push_back(mk(0, 0, 1, 5, 6, 12, 3,     1,0,0, 5, 1,0,5, 0,3));
        vt.push_back(mk(0, 0, 1, 7, 8, 16, 3,     0,1,0, 6, 1,0,6, 0,3));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].st, vt[i].cnt, vt[i].v, vt[i].a, vt[i].b, vt[i].o, vt[i].op);
            tick();
            check($sformatf("v%0d_busy", i), f_busy, vt[i].e_busy);
            check($sformatf("v%0d_done", i), f_done, vt[i].e_done);
            check($sformatf("v%0d_pass", i), f_pass, vt[i].e_pass);
            check($sformatf("v%0d_to",   i), f_to,   0);
            check($sformatf("v%0d_err",  i), f_err,  vt[i].e_err);
            check($sformatf("v%0d_fev",  i), f_fev,  vt[i].e_fev);
            check($sformatf("v%0d_fei",  i), f_fei,  vt[i].e_fei);
            check($sformatf("v%0d_si",   i), f_si,   vt[i].e_si);
            check($sformatf("v%0d_mpass",i), m_pass, vt[i].e_mpass);
            check($sformatf("v%0d_merr", i), m_err,  vt[i].e_merr);
        end

        // timeout: two samples then silence
        drive(1'b1, 7'd4, 1'b0, 0, 0, 0, 0); tick();
        send_good_pair();
        idle_inputs();
        for (int k = 0; k < 15; k++) tick();
        check("to_busy15", f_busy, 1);
        check("to_done15", f_done, 0);
        tick();
        check("to_done16", f_done, 1);
        check("to_flag",   f_to, 1);
        check("to_pass",   f_pass, 0);
        check("to_si",     f_si, 2);
        check("to_mflag",  m_to, 1);

        // zero-length run
        drive(1'b1, 7'd0, 1'b0, 0, 0, 0, 0); tick();
        idle_inputs();
        check("z_done", f_done, 1);
        check("z_pass", f_pass, 1);
        check("z_to",   f_to, 0);
        check("z_busy", f_busy, 0);

        // reset mid-run; a table write during the run must be dropped
        drive(1'b1, 7'd4, 1'b0, 0, 0, 0, 0); tick();
        send_good_pair();
        idle_inputs();
        exp_we = 1'b1; exp_addr = 6'd0; exp_wdata = '0;
        tick();
        exp_we = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("mr_busy", f_busy, 0);
        check("mr_done", f_done, 0);
        check("mr_pass", f_pass, 0);
        check("mr_err",  f_err, 0);
        check("mr_fev",  f_fev, 0);
        check("mr_si",   f_si, 0);
        check("mr_to",   f_to, 0);

        // start together with a valid (wrong) sample: sample not compared
        drive(1'b1, 7'd4, 1'b1, 32'd99, 32'd99, 32'd99, 3'd7); tick();
        check("sv_busy", f_busy, 1);
        check("sv_si",   f_si, 0);
        check("sv_err",  f_err, 0);
        send_good_pair();
        drive(1'b0, 7'd0, 1'b1, 32'd10, 32'd20, 32'd30, 3'd2); tick();
        drive(1'b0, 7'd0, 1'b1, 32'd0,  32'd0,  32'd0,  3'd2); tick();
        idle_inputs();
        check("rr_done",  f_done, 1);
        check("rr_pass",  f_pass, 1);
        check("rr_err",   f_err, 0);
        check("rr_si",    f_si, 4);
        check("rr_mpass", m_pass, 1);
        tick(); tick();
        check("rr_hold",  f_pass, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
